// File: rtl/zb_link_sequencer.sv
// Half-duplex link sequencer: gates inFIFO reads into the MSK modulator during TX and moves
// CDR bits into outFIFO during RX, with frame bit counting, idle timeouts and status pulses.
module zb_link_sequencer #(
  parameter int FRAME_BITS = 32,
  parameter int TIMEOUT    = 1024,
  parameter int GUARD      = 16
) (
  input  logic                              inClock,
  input  logic                              inReset,
  input  logic                              inStart,
  input  logic                              inRxArm,
  input  logic                              inFifoEmpty,
  output logic                              outFifoReadEnable,
  input  logic                              inCoderReady,
  output logic                              outCoderEmpty,
  input  logic                              inCdrFlag,
  input  logic                              inCdrData,
  input  logic                              inOutFifoFull,
  output logic                              outOutFifoWriteEnable,
  output logic                              outOutFifoData,
  output logic [2:0]                        outState,
  output logic [$clog2(FRAME_BITS+1)-1:0]   outBitCount,
  output logic                              outTxDone,
  output logic                              outRxDone,
  output logic                              outTimeout,
  output logic                              outOverflow
);

  localparam int CW        = $clog2(FRAME_BITS + 1);
  localparam int TMR_RANGE = (TIMEOUT > GUARD) ? TIMEOUT : GUARD;
  localparam int TW        = $clog2(TMR_RANGE + 1);

  localparam logic [CW-1:0] LAST_BIT   = CW'(FRAME_BITS - 1);
  localparam logic [CW-1:0] CNT_MAX    = CW'(FRAME_BITS);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] GUARD_LAST = TW'(GUARD - 1);
  localparam logic [TW-1:0] TMR_MAX    = '1;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_TX       = 3'd1,
    S_TX_FLUSH = 3'd2,
    S_RX       = 3'd3
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [TW-1:0] tmr_q, tmr_d, tmr_inc;
  logic          data_q, data_d;
  logic          wr_q, wr_d;
  logic          ovf_q, ovf_d;
  logic          tx_done_q, tx_done_d;
  logic          rx_done_q, rx_done_d;
  logic          tmo_q, tmo_d;
  logic          rd_en;
  logic          coder_empty;

  // Both counters saturate rather than wrap.
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
  assign tmr_inc = (tmr_q == TMR_MAX) ? tmr_q : tmr_q + 1'b1;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    tmr_d       = tmr_q;
    data_d      = data_q;
    wr_d        = 1'b0;
    ovf_d       = 1'b0;
    tx_done_d   = 1'b0;
    rx_done_d   = 1'b0;
    tmo_d       = 1'b0;
    rd_en       = 1'b0;
    coder_empty = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (inStart && !inFifoEmpty) begin
          state_d = S_TX;
          cnt_d   = '0;
          tmr_d   = '0;
        end else if (inRxArm) begin
          state_d = S_RX;
          cnt_d   = '0;
          tmr_d   = '0;
        end
      end

      S_TX: begin
        coder_empty = inFifoEmpty;
        rd_en       = inCoderReady & ~inFifoEmpty;
        if (rd_en) begin
          cnt_d = cnt_inc;
          tmr_d = '0;
          if (cnt_q == LAST_BIT) state_d = S_TX_FLUSH;
        end else if (tmr_q == TMO_LAST) begin
          state_d = S_IDLE;
          tmo_d   = 1'b1;
        end else begin
          tmr_d = tmr_inc;
        end
      end

      // The timer was cleared by the final read, so here it counts guard cycles.
      S_TX_FLUSH: begin
        if (tmr_q == GUARD_LAST) begin
          state_d   = S_IDLE;
          tx_done_d = 1'b1;
        end else begin
          tmr_d = tmr_inc;
        end
      end

      S_RX: begin
        if (inCdrFlag) begin
          data_d = inCdrData;
          cnt_d  = cnt_inc;
          tmr_d  = '0;
          wr_d   = ~inOutFifoFull;
          ovf_d  = inOutFifoFull;
          // A completing bit always wins over a coincident timeout.
          if (cnt_q == LAST_BIT) begin
            state_d   = S_IDLE;
            rx_done_d = 1'b1;
          end
        end else if (tmr_q == TMO_LAST) begin
          state_d = S_IDLE;
          tmo_d   = 1'b1;
        end else begin
          tmr_d = tmr_inc;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: reset is sampled on the clock edge only; all state uses non-blocking assignments.
  always_ff @(posedge inClock) begin
    if (!inReset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      tmr_q     <= '0;
      data_q    <= 1'b0;
      wr_q      <= 1'b0;
      ovf_q     <= 1'b0;
      tx_done_q <= 1'b0;
      rx_done_q <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tmr_q     <= tmr_d;
      data_q    <= data_d;
      wr_q      <= wr_d;
      ovf_q     <= ovf_d;
      tx_done_q <= tx_done_d;
      rx_done_q <= rx_done_d;
      tmo_q     <= tmo_d;
    end
  end

  assign outFifoReadEnable     = rd_en;
  assign outCoderEmpty         = coder_empty;
  assign outOutFifoWriteEnable = wr_q;
  assign outOutFifoData        = data_q;
  assign outState              = state_q;
  assign outBitCount           = cnt_q;
  assign outTxDone             = tx_done_q;
  assign outRxDone             = rx_done_q;
  assign outTimeout            = tmo_q;
  assign outOverflow           = ovf_q;

endmodule

// File: tb/tb_zb_link_sequencer.sv
// Scoreboard bench for zb_link_sequencer: stimulus queues expected output events, a negedge
// monitor pops and compares them, and directed checks cover state, counts and timing.
module tb_zb_link_sequencer;

  localparam int FRAME_BITS = 32;
  localparam int TIMEOUT    = 1024;
  localparam int GUARD      = 16;
  localparam int CW         = $clog2(FRAME_BITS + 1);

  typedef enum logic [2:0] {EV_RD, EV_WR, EV_OVF, EV_RXDONE, EV_TXDONE, EV_TMO} ev_kind_e;
  typedef struct packed {
    ev_kind_e   kind;
    logic [7:0] val;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst_n_i, start, rx_arm, fifo_empty, coder_ready, cdr_flag, cdr_data, out_full;
  logic          rd_en, coder_empty, wr_en, wr_data, tx_done, rx_done, tmo, ovf;
  logic [2:0]    state;
  logic [CW-1:0] bit_count;

  int   n_checks = 0;
  int   n_pass   = 0;
  ev_t  exp_q[$];
  bit   mon_en   = 1'b0;
  logic prev_flag = 1'b0;

  // Minimal inFIFO occupancy model driving the empty flag.
  int   fifo_cnt  = 0;
  int   preload_n = 0;
  logic preload_req = 1'b0;

  always #5 clk = ~clk;

  zb_link_sequencer #(.FRAME_BITS(FRAME_BITS), .TIMEOUT(TIMEOUT), .GUARD(GUARD)) dut (
    .inClock              (clk),
    .inReset              (rst_n_i),
    .inStart              (start),
    .inRxArm              (rx_arm),
    .inFifoEmpty          (fifo_empty),
    .outFifoReadEnable    (rd_en),
    .inCoderReady         (coder_ready),
    .outCoderEmpty        (coder_empty),
    .inCdrFlag            (cdr_flag),
    .inCdrData            (cdr_data),
    .inOutFifoFull        (out_full),
    .outOutFifoWriteEnable(wr_en),
    .outOutFifoData       (wr_data),
    .outState             (state),
    .outBitCount          (bit_count),
    .outTxDone            (tx_done),
    .outRxDone            (rx_done),
    .outTimeout           (tmo),
    .outOverflow          (ovf)
  );

  assign fifo_empty = (fifo_cnt == 0);

  always @(posedge clk) begin
    if (preload_req) fifo_cnt <= preload_n;
    else if (rd_en)  fifo_cnt <= fifo_cnt - 1;
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic expect_ev(input ev_kind_e k, input int v);
    ev_t e;
    e.kind = k;
    e.val  = 8'(v);
    exp_q.push_back(e);
  endtask

  task automatic observe(input ev_kind_e k, input int v);
    ev_t e;
    if (exp_q.size() == 0) begin
      check($sformatf("unexpected %s event", k.name()), v, -1);
    end else begin
      e = exp_q.pop_front();
      check($sformatf("event kind (saw %s)", k.name()), int'(k), int'(e.kind));
      check($sformatf("%s value", k.name()), v, int'(e.val));
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (rd_en) begin
        observe(EV_RD, int'(bit_count));
        check("read coincides with coder ready", int'(coder_ready), 1);
      end
      if (wr_en) begin
        observe(EV_WR, int'(wr_data));
        check("write one cycle after flag", int'(prev_flag), 1);
      end
      if (ovf) begin
        observe(EV_OVF, int'(bit_count));
        check("overflow one cycle after flag", int'(prev_flag), 1);
      end
      if (rx_done) begin
        observe(EV_RXDONE, int'(bit_count));
        check("rx_done with final write", int'(wr_en), 1);
        check("rx_done state", int'(state), 0);
      end
      if (tx_done) begin
        observe(EV_TXDONE, int'(bit_count));
        check("tx_done state", int'(state), 0);
      end
      if (tmo) begin
        observe(EV_TMO, int'(bit_count));
        check("timeout state", int'(state), 0);
      end
    end
    prev_flag = cdr_flag;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input int n);
    preload_n   = n;
    preload_req = 1'b1;
    tick();
    preload_req = 1'b0;
  endtask

  task automatic rx_frame(input logic [31:0] pat, input int full_lo, input int full_hi);
    rx_arm = 1'b1;
    tick();
    rx_arm = 1'b0;
    check("rx entered", int'(state), 3);
    for (int i = 0; i < FRAME_BITS; i++) begin
      cdr_flag = 1'b1;
      cdr_data = pat[31-i];
      out_full = (i >= full_lo && i <= full_hi);
      if (out_full) expect_ev(EV_OVF, i + 1);
      else          expect_ev(EV_WR, int'(pat[31-i]));
      if (i == FRAME_BITS - 1) expect_ev(EV_RXDONE, FRAME_BITS);
      tick();
      cdr_flag = 1'b0;
      out_full = 1'b0;
      if (i % 4 == 3 && i != FRAME_BITS - 1) tick();
    end
    check("rx done pulse", int'(rx_done), 1);
    check("rx final state", int'(state), 0);
    check("rx final count", int'(bit_count), FRAME_BITS);
    tick();
    check("rx done is one cycle", int'(rx_done), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached, checks so far %0d/%0d", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst_n_i = 1'b0; start = 1'b0; rx_arm = 1'b0; coder_ready = 1'b0;
    cdr_flag = 1'b0; cdr_data = 1'b0; out_full = 1'b0;
    repeat (3) tick();
    check("reset state", int'(state), 0);
    check("reset count", int'(bit_count), 0);
    check("reset coder_empty", int'(coder_empty), 1);
    check("reset read enable", int'(rd_en), 0);
    check("reset write/data/pulses", int'({wr_en, wr_data, tx_done, rx_done, tmo, ovf}), 0);
    rst_n_i = 1'b1;
    mon_en  = 1'b1;

    // TX frame with coder ready one cycle in three.
    preload(FRAME_BITS);
    for (int i = 0; i < FRAME_BITS; i++) expect_ev(EV_RD, i);
    expect_ev(EV_TXDONE, FRAME_BITS);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("tx entered", int'(state), 1);
    check("tx coder_empty follows fifo", int'(coder_empty), 0);
    n = 0;
    while (state == 3'd1 && n < 300) begin
      coder_ready = (n % 3 == 0);
      tick();
      n++;
    end
    coder_ready = 1'b0;
    check("tx reached flush", int'(state), 2);
    check("tx count at flush", int'(bit_count), FRAME_BITS);
    n = 0;
    while (state == 3'd2 && n < 100) begin
      tick();
      n++;
    end
    check("flush cycles", n, GUARD);
    check("tx done pulse", int'(tx_done), 1);
    tick();
    check("tx done is one cycle", int'(tx_done), 0);
    check("tx idle count held", int'(bit_count), FRAME_BITS);
    check("tx idle state", int'(state), 0);

    // TX underrun: 10 bits then timeout.
    preload(10);
    for (int i = 0; i < 10; i++) expect_ev(EV_RD, i);
    expect_ev(EV_TMO, 10);
    start = 1'b1;
    coder_ready = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (fifo_cnt != 0 && n < 50) begin
      tick();
      n++;
    end
    check("underrun still tx", int'(state), 1);
    check("underrun coder_empty", int'(coder_empty), 1);
    check("underrun count", int'(bit_count), 10);
    n = 0;
    while (state == 3'd1 && n < 2000) begin
      tick();
      n++;
    end
    check("timeout idle cycles", n, TIMEOUT);
    check("timeout pulse", int'(tmo), 1);
    check("timeout count held", int'(bit_count), 10);
    coder_ready = 1'b0;
    tick();
    check("timeout is one cycle", int'(tmo), 0);

    // RX frame, then RX with outFIFO full on bits 5..7.
    rx_frame(32'hA5A5_A5A5, -1, -1);
    rx_frame(32'h3C0F_F00D, 5, 7);

    // Priority, then reset in the middle of a TX frame.
    preload(20);
    for (int i = 0; i < 12; i++) expect_ev(EV_RD, i);
    start  = 1'b1;
    rx_arm = 1'b1;
    tick();
    start  = 1'b0;
    rx_arm = 1'b0;
    check("start beats rx_arm", int'(state), 1);
    coder_ready = 1'b1;
    repeat (12) tick();
    coder_ready = 1'b0;
    check("pre-reset count", int'(bit_count), 12);
    rst_n_i = 1'b0;
    tick();
    check("mid-frame reset state", int'(state), 0);
    check("mid-frame reset count", int'(bit_count), 0);
    check("mid-frame reset coder_empty", int'(coder_empty), 1);
    check("mid-frame reset pulses", int'({wr_en, tx_done, rx_done, tmo, ovf, rd_en}), 0);
    rst_n_i = 1'b1;
    tick();
    check("post-reset idle", int'(state), 0);

    // Start with an empty inFIFO is ignored.
    preload(0);
    start = 1'b1;
    coder_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("empty start stays idle", int'(state), 0);
      check("empty start no read", int'(rd_en), 0);
    end
    start = 1'b0;
    coder_ready = 1'b0;

    repeat (3) tick();
    check("scoreboard drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
